// File: rtl/fetch_req_ctrl.sv
// Instruction fetch request controller: issues word fetches under an outstanding/FIFO-space limit and squashes stale responses after a branch.
// Optional feature: define FETCH_REQ_DISCARD_CNT_EN to count discarded responses on discard_cnt_o.
module fetch_req_ctrl #(
  parameter int          NUM_REQS  = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_i,
  input  logic                             branch_i,
  input  logic [31:0]                      addr_i,
  input  logic [$clog2(NUM_REQS+1)-1:0]    fifo_free_i,
  output logic                             instr_req_o,
  output logic [31:0]                      instr_addr_o,
  input  logic                             instr_gnt_i,
  input  logic                             instr_rvalid_i,
  input  logic [31:0]                      instr_rdata_i,
  input  logic                             instr_err_i,
  output logic                             out_valid_o,
  output logic [31:0]                      out_addr_o,
  output logic [31:0]                      out_rdata_o,
  output logic                             out_err_o,
  output logic                             clear_o,
  output logic [15:0]                      discard_cnt_o
);

  localparam int              OCW       = $clog2(NUM_REQS + 1);
  localparam logic [OCW-1:0]  MAX_OC    = OCW'(NUM_REQS);
  localparam logic [29:0]     BOOT_WORD = BOOT_ADDR[31:2];

  logic [OCW-1:0] oc, oc_next;
  logic [OCW-1:0] sq, sq_next;
  logic [29:0]    fp, rp, redir_addr;
  logic           redir;
  logic           held;
  logic           fresh, issue, pend;
  logic           unused_addr_bits;

  assign unused_addr_bits = ^addr_i[1:0];

  // A new request may only start when nothing is held; a held one ignores req/branch/space.
  assign fresh       = req_i & (oc < MAX_OC) & (oc < fifo_free_i) & ~branch_i;
  assign instr_req_o = rst_ni & (held | fresh);
  assign issue       = instr_req_o & instr_gnt_i;
  assign pend        = instr_req_o & ~instr_gnt_i;

  assign clear_o      = rst_ni & branch_i;
  assign out_valid_o  = rst_ni & instr_rvalid_i & (sq == '0) & ~branch_i;
  assign out_rdata_o  = instr_rdata_i;
  assign out_err_o    = instr_err_i;
  assign instr_addr_o = {fp, 2'b00};
  assign out_addr_o   = {rp, 2'b00};

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    oc_next = oc;
    if (issue && !instr_rvalid_i)      oc_next = oc + OCW'(1);
    else if (!issue && instr_rvalid_i) oc_next = oc - OCW'(1);
  end

  // Squash everything granted plus a request still waiting for its grant.
  always_comb begin
    sq_next = sq;
    if (branch_i)                        sq_next = oc_next + OCW'(pend);
    else if (instr_rvalid_i && sq != '0) sq_next = sq - OCW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oc <= '0;
      sq <= '0;
    end else begin
      oc <= oc_next;
      sq <= sq_next;
    end
  end

  // A branch during a held request is parked in redir_addr so the held address stays stable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fp         <= BOOT_WORD;
      rp         <= BOOT_WORD;
      redir_addr <= BOOT_WORD;
      redir      <= 1'b0;
      held       <= 1'b0;
    end else begin
      held <= pend;
      if (branch_i) begin
        rp <= addr_i[31:2];
        if (pend) begin
          redir      <= 1'b1;
          redir_addr <= addr_i[31:2];
        end else begin
          fp    <= addr_i[31:2];
          redir <= 1'b0;
        end
      end else begin
        if (out_valid_o) rp <= rp + 30'd1;
        if (issue) begin
          fp    <= redir ? redir_addr : fp + 30'd1;
          redir <= 1'b0;
        end
      end
    end
  end

`ifdef FETCH_REQ_DISCARD_CNT_EN
  logic [15:0] discard_cnt;
  logic        drop;

  assign drop = instr_rvalid_i & ~out_valid_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              discard_cnt <= 16'h0000;
    else if (drop && discard_cnt != 16'hFFFF) discard_cnt <= discard_cnt + 16'd1;
  end

  assign discard_cnt_o = discard_cnt;
`else
  assign discard_cnt_o = 16'h0000;
`endif

`ifndef SYNTHESIS
  a_rvalid_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_rvalid_i && oc == '0));
  a_req_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(instr_req_o && oc == MAX_OC));
`endif

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Testbench for fetch_req_ctrl: directed scenarios then random traffic, checked against a
// request-queue reference model (each granted fetch carries its address and a squashed flag).
module tb_fetch_req_ctrl;

  localparam int N  = 2;
  localparam int FW = $clog2(N + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          req_i, branch_i;
  logic [31:0]   addr_i;
  logic [FW-1:0] fifo_free_i;
  logic          instr_req_o;
  logic [31:0]   instr_addr_o;
  logic          instr_gnt_i, instr_rvalid_i;
  logic [31:0]   instr_rdata_i;
  logic          instr_err_i;
  logic          out_valid_o;
  logic [31:0]   out_addr_o, out_rdata_o;
  logic          out_err_o, clear_o;
  logic [15:0]   discard_cnt_o;

  fetch_req_ctrl #(.NUM_REQS(N), .BOOT_ADDR(32'h0000_0080)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .branch_i(branch_i), .addr_i(addr_i),
    .fifo_free_i(fifo_free_i), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .out_valid_o(out_valid_o), .out_addr_o(out_addr_o),
    .out_rdata_o(out_rdata_o), .out_err_o(out_err_o), .clear_o(clear_o),
    .discard_cnt_o(discard_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    bit          squashed;
  } ent_t;

  // Reference model state
  ent_t        outq[$];
  logic [31:0] nxt;
  logic [31:0] held_addr;
  bit          held, held_sq;
  int unsigned disc;

  int n_cmp  = 0;
  int n_fail = 0;

  // Values seen at the most recent sample point, for directed anchors
  logic [31:0] seen_iaddr, seen_oaddr;
  logic        seen_req, seen_clear, seen_oval, seen_oerr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_discard(input int unsigned d);
`ifdef FETCH_REQ_DISCARD_CNT_EN
    return d[15:0];
`else
    return (d == 0) ? 16'h0000 : 16'h0000;
`endif
  endfunction

  task automatic model_reset();
    outq.delete();
    held      = 0;
    held_sq   = 0;
    held_addr = '0;
    nxt       = 32'h0000_0080;
    disc      = 0;
  endtask

  task automatic idle_inputs();
    req_i = 0; branch_i = 0; addr_i = '0; fifo_free_i = FW'(N);
    instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = '0; instr_err_i = 0;
  endtask

  // Asserts reset asynchronously (mid-cycle) with busy inputs, checks reset outputs, releases.
  task automatic do_reset();
    rst_ni = 0;
    req_i = 1; branch_i = 1; addr_i = 32'hDEAD_BEEF; fifo_free_i = FW'(N);
    instr_gnt_i = 1; instr_rvalid_i = 1; instr_rdata_i = 32'h1234_5678; instr_err_i = 1;
    #2;
    check("rst_instr_req", instr_req_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_clear", clear_o, 1'b0);
    check("rst_instr_addr", instr_addr_o, 32'h0000_0080);
    check("rst_out_addr", out_addr_o, 32'h0000_0080);
    check("rst_discard", discard_cnt_o, 16'h0000);
    model_reset();
    @(negedge clk_i);
    idle_inputs();
    #2 rst_ni = 1;
    @(posedge clk_i);
    #1;
  endtask

  // One clock: drive inputs, sample outputs at the falling edge, advance the model.
  task automatic cycle(input bit req, input bit br, input logic [31:0] baddr, input int free,
                       input bit gnt, input bit rv, input bit err);
    bit          rv_e, exp_req, deliver;
    logic [31:0] exp_addr, rdata;
    ent_t        e;
    rv_e  = rv && (outq.size() > 0);
    rdata = $urandom();
    req_i = req; branch_i = br; addr_i = baddr; fifo_free_i = FW'(free);
    instr_gnt_i = gnt; instr_rvalid_i = rv_e; instr_rdata_i = rdata; instr_err_i = err;
    @(negedge clk_i);
    exp_req  = held || (req && outq.size() < N && outq.size() < free && !br);
    exp_addr = held ? held_addr : nxt;
    deliver  = rv_e && !br && !outq[0].squashed;
    seen_req = instr_req_o; seen_iaddr = instr_addr_o; seen_clear = clear_o;
    seen_oval = out_valid_o; seen_oaddr = out_addr_o; seen_oerr = out_err_o;
    check("instr_req", instr_req_o, exp_req);
    if (exp_req) check("instr_addr", instr_addr_o, exp_addr);
    check("clear", clear_o, br);
    check("out_valid", out_valid_o, deliver);
    if (deliver) begin
      check("out_addr", out_addr_o, outq[0].addr);
      check("out_rdata", out_rdata_o, rdata);
      check("out_err", out_err_o, err);
    end
    check("discard_cnt", discard_cnt_o, exp_discard(disc));
    // Advance the model to the next edge
    if (rv_e) begin
      e = outq.pop_front();
      if (!deliver && disc < 65535) disc++;
    end
    if (exp_req && gnt) begin
      e.addr     = exp_addr;
      e.squashed = held ? held_sq : 1'b0;
      outq.push_back(e);
      if (!br && !e.squashed) nxt = exp_addr + 32'd4;
    end
    if (br) begin
      foreach (outq[i]) outq[i].squashed = 1'b1;
      nxt = {baddr[31:2], 2'b00};
    end
    if (exp_req && !gnt) begin
      held_sq   = (held && held_sq) || br;
      held_addr = exp_addr;
      held      = 1;
    end else begin
      held    = 0;
      held_sq = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst_ni = 1;
    #1;
    do_reset();

    // Streaming fetch from boot address, grant every cycle, response one cycle later
    cycle(1, 0, 0, 2, 1, 0, 0);
    check("boot_issue", seen_iaddr, 32'h0000_0080);
    cycle(1, 0, 0, 2, 1, 1, 0);
    check("issue_84", seen_iaddr, 32'h0000_0084);
    check("resp_80", seen_oaddr, 32'h0000_0080);
    cycle(1, 0, 0, 2, 1, 1, 0);
    check("issue_88", seen_iaddr, 32'h0000_0088);
    check("resp_84", seen_oaddr, 32'h0000_0084);
    cycle(0, 0, 0, 2, 0, 1, 0);
    check("resp_88", seen_oaddr, 32'h0000_0088);

    // No FIFO space blocks requests; one free entry allows exactly one in flight
    repeat (3) cycle(1, 0, 0, 0, 1, 0, 0);
    check("free0_noreq", seen_req, 1'b0);
    cycle(1, 0, 0, 1, 1, 0, 0);
    check("free1_req", seen_req, 1'b1);
    repeat (3) cycle(1, 0, 0, 1, 1, 0, 0);
    check("free1_blocked", seen_req, 1'b0);
    cycle(1, 0, 0, 1, 1, 1, 0);
    cycle(1, 0, 0, 1, 1, 0, 0);
    check("free1_resume", seen_req, 1'b1);
    cycle(0, 0, 0, 1, 0, 1, 0);

    // Branch while a request is held ungranted
    do_reset();
    cycle(1, 0, 0, 2, 1, 0, 0);
    cycle(1, 0, 0, 2, 0, 1, 0);
    cycle(1, 1, 32'h0000_1003, 2, 0, 0, 0);
    check("held_addr_br", seen_iaddr, 32'h0000_0084);
    check("held_clear", seen_clear, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 0);
    check("held_req", seen_req, 1'b1);
    check("held_addr", seen_iaddr, 32'h0000_0084);
    cycle(0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 2, 0, 1, 0);
    check("redir_addr", seen_iaddr, 32'h0000_1000);
    check("drop_84", seen_oval, 1'b0);
    cycle(1, 0, 0, 2, 1, 0, 0);
    cycle(0, 0, 0, 2, 0, 1, 0);
    check("resp_1000", seen_oaddr, 32'h0000_1000);

    // Branch coincident with a response at two outstanding
    do_reset();
    cycle(1, 0, 0, 2, 1, 0, 0);
    cycle(1, 0, 0, 2, 1, 0, 0);
    cycle(1, 1, 32'h0000_2000, 2, 0, 1, 0);
    check("drop_brcyc", seen_oval, 1'b0);
    cycle(0, 0, 0, 2, 0, 1, 0);
    check("drop_sq", seen_oval, 1'b0);
    cycle(1, 0, 0, 2, 1, 0, 0);
    check("issue_2000", seen_iaddr, 32'h0000_2000);
    cycle(0, 0, 0, 2, 0, 1, 0);
    check("resp_2000_valid", seen_oval, 1'b1);
    check("resp_2000", seen_oaddr, 32'h0000_2000);
`ifdef FETCH_REQ_DISCARD_CNT_EN
    check("discard_two", discard_cnt_o, 16'd2);
`else
    check("discard_off", discard_cnt_o, 16'd0);
`endif

    // Error response is forwarded while fetch continues
    cycle(1, 0, 0, 2, 1, 0, 0);
    cycle(1, 0, 0, 2, 1, 1, 1);
    check("err_fwd", seen_oerr, 1'b1);
    check("err_next_issue", seen_iaddr, 32'h0000_2008);
    cycle(0, 0, 0, 2, 0, 1, 0);

    // Random traffic, including occasional mid-transaction resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, $urandom(),
              int'($urandom_range(0, N)), $urandom_range(0, 9) < 6,
              $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
